// File: rtl/mul_iterative.sv
// rtl/mul_iterative.sv - iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
// Works on magnitudes, one multiplier bit per cycle, then applies the sign in a single fix-up step.
module mul_iterative #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_res,
    output logic            o_busy,
    output logic            o_done
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      op;
    logic            neg;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   cnt;

    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [2*XLEN-1:0] prod_fix;

    // rs1 is signed for every op except MULHU; rs2 only for MUL/MULH
    always_comb begin
        sign1    = i_rs1[XLEN-1] & (i_op != 2'b11);
        sign2    = i_rs2[XLEN-1] & ~i_op[1];
        mag1     = sign1 ? -i_rs1 : i_rs1;
        mag2     = sign2 ? -i_rs2 : i_rs2;
        prod_fix = neg ? -prod : prod;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state  <= IDLE;
            op     <= '0;
            neg    <= 1'b0;
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
            o_res  <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        op     <= i_op;
                        neg    <= sign1 ^ sign2;
                        mcand  <= {{XLEN{1'b0}}, mag1};
                        mplier <= mag2;
                        prod   <= '0;
                        cnt    <= CW'(XLEN);
                        o_busy <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // result registered here so o_done and o_res appear together in the DONE cycle
                    prod   <= prod_fix;
                    o_res  <= (op == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                    o_done <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
